// File: rtl/gcd_arbiter_if.sv
// gcd_arbiter_if: bundles the requester-side and core-side signals of the
// GCD arbiter.
//   req_valid/req_data/req_ready    : per-requester operand handoff
//   resp_valid/resp_data/resp_err/resp_ready : per-requester result return
//   core_in_*/core_out_*/core_reset : link to the shared GCD core
//   busy                            : arbiter not idle
// modport slave  : the arbiter itself
// modport master : the environment (requesters plus the core)
interface gcd_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [15:0]          resp_data;
  logic                 resp_err;
  logic [NREQ-1:0]      resp_ready;
  logic                 core_in_valid;
  logic [31:0]          core_in_data;
  logic                 core_in_ready;
  logic                 core_out_valid;
  logic [15:0]          core_out_data;
  logic                 core_reset;
  logic                 busy;

  modport slave (
    input  req_valid, req_data, resp_ready,
    input  core_in_ready, core_out_valid, core_out_data,
    output req_ready, resp_valid, resp_data, resp_err,
    output core_in_valid, core_in_data, core_reset, busy
  );

  modport master (
    output req_valid, req_data, resp_ready,
    output core_in_ready, core_out_valid, core_out_data,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  core_in_valid, core_in_data, core_reset, busy
  );
endinterface

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one 16-bit GCD core between NREQ requesters using
// round-robin arbitration, one operation in flight at a time. A watchdog
// aborts an operation that does not complete within TIMEOUT cycles of WAIT,
// pulsing core_reset and returning result 0 with resp_err=1.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : gcd_arbiter_if.slave (requester handshakes, core link, busy)
module gcd_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  gcd_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   grant_q;
  logic [TW-1:0]   timer_q;
  logic [31:0]     op_q;
  logic [15:0]     result_q;
  logic            err_q;

  logic            any_req;
  logic [PW-1:0]   sel;
  logic [PW:0]     arb_idx;
  logic [31:0]     slot [NREQ];
  logic            timeout_hit;
  logic            flush_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      assign slot[gi] = bus.req_data[32*gi +: 32];
    end
  endgenerate

  // First valid request at or after rr_ptr, wrapping. The index is one bit
  // wider than the pointer so the explicit modulo works for any NREQ.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    arb_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (arb_idx >= (PW+1)'(NREQ)) arb_idx = arb_idx - (PW+1)'(NREQ);
      if (!any_req && bus.req_valid[arb_idx[PW-1:0]]) begin
        any_req = 1'b1;
        sel     = arb_idx[PW-1:0];
      end
    end
  end

  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));
  // Completion wins over the watchdog in the same cycle.
  assign flush_pulse = (state_q == WAIT) && !bus.core_out_valid && timeout_hit;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_out
      // req_ready is combinational from IDLE; gating with reset keeps it low
      // while reset is asserted even if requests are present.
      assign bus.req_ready[gi]  = reset && (state_q == IDLE) && any_req &&
                                  (sel == PW'(gi));
      assign bus.resp_valid[gi] = (state_q == RESP) && (grant_q == PW'(gi));
    end
  endgenerate

  assign bus.resp_data     = result_q;
  assign bus.resp_err      = err_q;
  assign bus.core_in_valid = (state_q == ISSUE);
  assign bus.core_in_data  = op_q;
  assign bus.core_reset    = ~reset | flush_pulse;
  assign bus.busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      timer_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= sel;
            op_q    <= slot[sel];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.core_in_ready) begin
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.core_out_valid) begin
            result_q <= bus.core_out_data;
            err_q    <= 1'b0;
            state_q  <= RESP;
          end else if (timeout_hit) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state_q  <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready[grant_q]) begin
            rr_ptr_q <= (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
module tb_gcd_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.NREQ(NREQ)) bus ();

  gcd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- GCD core model ----------------
  // Euclid by remainder, one step per cycle. y==0 with x>0 never finishes.
  logic        c_busy;
  logic [15:0] cx, cy;
  assign bus.core_in_ready = !c_busy;

  always @(posedge clk) begin
    bus.core_out_valid <= 1'b0;
    if (bus.core_reset) begin
      c_busy <= 1'b0;
    end else if (!c_busy) begin
      if (bus.core_in_valid) begin
        cx     <= bus.core_in_data[31:16];
        cy     <= bus.core_in_data[15:0];
        c_busy <= 1'b1;
      end
    end else begin
      if (cx == 16'd0) begin
        bus.core_out_valid <= 1'b1; bus.core_out_data <= cy; c_busy <= 1'b0;
      end else if (cy == 16'd0) begin
        c_busy <= 1'b1;
      end else if (cx >= cy) begin
        if (cx % cy == 16'd0) begin
          bus.core_out_valid <= 1'b1; bus.core_out_data <= cy; c_busy <= 1'b0;
        end else cx <= cx % cy;
      end else begin
        if (cy % cx == 16'd0) begin
          bus.core_out_valid <= 1'b1; bus.core_out_data <= cx; c_busy <= 1'b0;
        end else cy <= cy % cx;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  initial begin : monitor
    exp_t e;
    logic [NREQ-1:0] want;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (bus.resp_valid & bus.resp_ready) != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: valid=%b data=%0d err=%b, required no response",
                   bus.resp_valid, bus.resp_data, bus.resp_err);
        end else begin
          e    = sb.pop_front();
          want = '0;
          want[e.idx] = 1'b1;
          $display("resp req=%0d data=%0d err=%0b", e.idx, bus.resp_data, bus.resp_err);
          if (bus.resp_valid !== want || bus.resp_data !== e.data || bus.resp_err !== e.err) begin
            errors++;
            $display("FAIL resp: valid=%b data=%0d err=%b, required valid=%b data=%0d err=%b",
                     bus.resp_valid, bus.resp_data, bus.resp_err, want, e.data, e.err);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0]     opq [NREQ][$];
  logic [NREQ-1:0] acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic req(input int i, input logic [15:0] x, input logic [15:0] y);
    opq[i].push_back({x, y});
  endtask

  task automatic expect_resp(input int i, input logic [15:0] d, input logic e);
    exp_t t;
    t.idx = i; t.data = d; t.err = e;
    sb.push_back(t);
  endtask

  function automatic bit opq_pending();
    for (int i = 0; i < NREQ; i++) if (opq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic at_neg();
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
  endtask

  // Drop accepted requests and present the next queued op per requester.
  task automatic at_pos();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req_valid[i] && opq[i].size() > 0) begin
        bus.req_data[32*i +: 32] = opq[i].pop_front();
        bus.req_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy || bus.req_valid != '0 || opq_pending()) && n < 400) begin
      at_neg();
      at_pos();
      n++;
    end
    chk("drain_timeout", 32'(n >= 400), 32'd0);
  endtask

  task automatic wait_neg(input string name, input int which);
    // which: 0 = core_in_valid, 1 = resp_valid[0]
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < 60) begin
      at_neg();
      hit = (which == 0) ? bus.core_in_valid : bus.resp_valid[0];
      if (!hit) begin at_pos(); n++; end
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  initial begin : stimulus
    int cnt;
    int bad;
    acc            = '0;
    reset          = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = '1;

    // Reset state, with a request present to prove req_ready is gated.
    bus.req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_core_in_valid", 32'(bus.core_in_valid), 32'd0);
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    bus.req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Round-robin with all requesters active; requester 0 re-requests.
    req(0, 12, 8); req(1, 35, 14); req(2, 9, 6); req(3, 17, 5); req(0, 12, 8);
    expect_resp(0, 4, 0); expect_resp(1, 7, 0); expect_resp(2, 3, 0);
    expect_resp(3, 1, 0); expect_resp(0, 4, 0);
    at_pos();
    drain();

    // Single op with held response.
    bus.resp_ready[0] = 1'b0;
    req(0, 48, 18); expect_resp(0, 6, 0);
    at_pos();
    at_neg();
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    at_pos();
    at_neg();
    chk("t1_req_ready_drop", 32'(bus.req_ready), 32'h0);
    chk("t1_core_in_valid", 32'(bus.core_in_valid), 32'd1);
    chk("t1_core_in_data", bus.core_in_data, {16'd48, 16'd18});
    at_pos();
    wait_neg("t1_resp_seen", 1);
    for (int k = 0; k < 3; k++) begin
      at_pos();
      at_neg();
      chk("t1_resp_hold_valid", 32'(bus.resp_valid), 32'h1);
      chk("t1_resp_hold_data", 32'(bus.resp_data), 32'd6);
    end
    at_pos();
    bus.resp_ready = '1;
    drain();

    // Watchdog on requester 2, then a normal op on requester 3.
    req(2, 5, 0); expect_resp(2, 0, 1);
    at_pos();
    wait_neg("t3_issue_seen", 0);
    cnt = 0;
    while (cnt < 40) begin
      at_pos();
      at_neg();
      cnt++;
      if (bus.core_reset) break;
    end
    chk("t3_flush_delay", 32'(cnt), 32'd16);
    at_pos();
    at_neg();
    chk("t3_flush_width", 32'(bus.core_reset), 32'd0);
    chk("t3_resp_valid", 32'(bus.resp_valid), 32'h4);
    at_pos();
    req(3, 10, 4); expect_resp(3, 2, 0);
    drain();

    // Response backpressure with requester 1 pending.
    bus.resp_ready[0] = 1'b0;
    req(0, 0, 7); expect_resp(0, 7, 0);
    at_pos();
    wait_neg("t4_resp_seen", 1);
    req(1, 1, 16'hFFFF); expect_resp(1, 1, 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      at_pos();
      at_neg();
      if (bus.resp_data !== 16'd7 || bus.req_ready !== '0 ||
          bus.core_in_valid !== 1'b0 || bus.resp_valid !== 4'h1) bad++;
    end
    chk("t4_stall_cycles_bad", 32'(bad), 32'd0);
    at_pos();
    bus.resp_ready = '1;
    at_neg();
    at_pos();
    at_neg();
    chk("t4_next_accept", 32'(bus.req_ready), 32'h2);
    at_pos();
    drain();

    // Equal operands.
    req(2, 7, 7); expect_resp(2, 7, 0);
    at_pos();
    drain();

    // Reset during WAIT: no response for the abandoned op, pointer back to 0.
    req(0, 5, 0);
    at_pos();
    wait_neg("t5_issue_seen", 0);
    for (int k = 0; k < 3; k++) begin at_pos(); at_neg(); end
    bus.req_data[127:96] = {16'd17, 16'd5};
    bus.req_valid[3] = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("t5_core_in_valid", 32'(bus.core_in_valid), 32'd0);
    chk("t5_core_reset", 32'(bus.core_reset), 32'd1);
    bus.req_data[31:0] = {16'd9, 16'd6};
    bus.req_valid[0] = 1'b1;
    expect_resp(0, 3, 0); expect_resp(3, 1, 0);
    acc = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Shares one 16-bit GCD core between NREQ requesters.
- Arbitration is round-robin, with one operation in flight at a time.
- Per-requester result return uses a valid/ready handshake.
- A watchdog recovers the core when it never completes; an operand y=0 with x>0 makes the core loop forever.
- Sits between client request ports and the GCD core's io_in/io_out interface.

Parameters:
NREQ, 4, number of requesters (2..16)
TIMEOUT, 1024, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request valid
req_data  in  32*NREQ  operand pair, slice i = bits [32i+31:32i]; {x[31:16], y[15:0]}
req_ready  out  NREQ  per-requester accept; one-hot or zero
resp_valid  out  NREQ  per-requester result valid; one-hot or zero
resp_data  out  16  result, shared by all requesters
resp_err  out  1  result aborted by watchdog; qualifies resp_data
resp_ready  in  NREQ  per-requester result accept
core_in_valid  out  1  to core io_in_valid
core_in_data  out  32  to core io_in_data
core_in_ready  in  1  from core io_in_ready
core_out_valid  in  1  from core io_out_valid; single-cycle pulse, no backpressure
core_out_data  in  16  from core io_out_data
core_reset  out  1  active-high synchronous reset to core
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, timer=0, grant=0, op/result registers=0.
  - All req_ready, resp_valid, core_in_valid=0; resp_err=0; busy=0.
  - core_reset = ~reset | flush_pulse. The core is therefore held in reset for the whole time reset is low.
  - Reset mid-operation abandons the in-flight op; no response is produced for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, select the first asserted index at or after rr_ptr, wrapping modulo NREQ.
  - In the same cycle: req_ready[g]=1 combinationally. On the edge: latch grant=g and op=req_data slice g; go to ISSUE.
  - No other req_ready is asserted.
  - No valid requests: remain in IDLE.
- ISSUE:
  - core_in_valid=1, core_in_data=op.
  - If core_in_ready=1: go to WAIT, timer=0.
  - Otherwise hold. The core is idle after reset or completion, so ISSUE normally lasts 1 cycle.
- WAIT:
  - timer increments every cycle.
  - core_out_valid=1: latch result=core_out_data, err=0; go to RESP. This takes priority over the timeout in the same cycle.
  - timer==TIMEOUT-1 with no core_out_valid: flush_pulse=1 for exactly that cycle (core_reset=1); latch result=0, err=1; go to RESP.
- RESP:
  - resp_valid[grant]=1, resp_data=result, resp_err=err, all held stable.
  - When resp_ready[grant]=1: go to IDLE and set rr_ptr=(grant+1) mod NREQ.
  - resp_ready on non-granted indices is ignored.
- core_out_valid outside WAIT is ignored; it cannot occur under the defined protocol.
- Fairness: a continuously requesting client waits at most NREQ-1 operations.
- Latencies:
  - Request accept to core issue: 1 cycle.
  - Core completion pulse to resp_valid: 1 cycle.
  - resp_ready to next accept: 1 cycle, since IDLE is re-entered first.
- Width rules:
  - timer is clog2(TIMEOUT) bits and never wraps; it is cleared on WAIT entry.
  - rr_ptr is clog2(NREQ) bits with explicit modulo for non-power-of-2 NREQ.

Test Plan:
1. Single op: req 0, data {48,18} → req_ready[0] for 1 cycle; core_in_valid next cycle; resp_valid[0] with resp_data=6, resp_err=0, held until resp_ready[0].
2. Round-robin: all 4 valid continuously, each with distinct ops ({12,8}→4, {35,14}→7, {9,6}→3, {17,5}→1) → grant order 0,1,2,3,0; each resp_valid is one-hot on the granted index only.
3. Watchdog: TIMEOUT=16, req 2 data {5,0} → after 16 WAIT cycles core_reset pulses 1 cycle; resp_valid[2] with resp_data=0, resp_err=1. A following {10,4} on req 3 returns 2 with err=0.
4. Response backpressure: hold resp_ready low 20 cycles with req 1 also pending → resp_data stable, req_ready stays 0, no core_in_valid. Release → req 1 accepted next cycle.
5. Reset mid-WAIT: assert reset during an op on req 0 → all outputs zero immediately (asynchronous), core_reset=1; no response after release; rr_ptr=0 so a simultaneous req 0 and req 3 grants 0 first.
6. Edge operands: {0,7} → 7; {7,7} → 7; {1,65535} → 1; both err=0.
